// File: rtl/gpio_pkg.sv
// Shared constants for the gpio core: input conditioner defaults that the
// ctrl register map also uses for its reset values.
package gpio_pkg;

    localparam int unsigned GPIO_SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned GPIO_DEBOUNCE_CNT_WIDTH  = 16;
    localparam logic [GPIO_DEBOUNCE_CNT_WIDTH-1:0] GPIO_DEBOUNCE_DEFAULT = 16'd1000;

    // Per-edge decision of one pin's debounce filter.
    typedef enum logic [1:0] {
        FILT_HOLD   = 2'd0,
        FILT_COUNT  = 2'd1,
        FILT_ACCEPT = 2'd2
    } filt_act_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin of the input conditioner: synchroniser chain, debounce counter,
// accepted level and registered rise/fall pulses.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT,
    parameter int unsigned CNT_WIDTH   = GPIO_DEBOUNCE_CNT_WIDTH,
    parameter logic        RESET_BIT   = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_pin,
    input  logic [CNT_WIDTH-1:0] i_neff,
    input  logic                 i_bypass,
    output logic                 o_level,
    output logic                 o_rise,
    output logic                 o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_WIDTH:0]     cnt_inc;
    logic                   s;
    filt_act_e              act;

    assign s = sync_q[SYNC_STAGES-1];
    // One extra bit so cnt+1 stays exact at the maximum threshold.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
        act    = FILT_HOLD;
        if (s != level_q) begin
            if (i_bypass || (cnt_inc >= {1'b0, i_neff})) begin
                act = FILT_ACCEPT;
            end else begin
                act = FILT_COUNT;
            end
        end

        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (act)
            FILT_COUNT: cnt_d = cnt_inc[CNT_WIDTH-1:0];
            FILT_ACCEPT: begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_BIT}};
            cnt_q   <= '0;
            level_q <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Input front-end of the gpio core: per-pin synchronise, debounce and edge
// detect, feeding DATA_IN and the pin-change IRQ logic.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT,
    parameter int unsigned     CNT_WIDTH   = GPIO_DEBOUNCE_CNT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [WIDTH-1:0]     i_pins,
    input  logic [CNT_WIDTH-1:0] i_debounce_cycles,
    input  logic [WIDTH-1:0]     i_bypass,
    output logic [WIDTH-1:0]     o_pins,
    output logic [WIDTH-1:0]     o_pin_change,
    output logic [WIDTH-1:0]     o_rise,
    output logic [WIDTH-1:0]     o_fall
);

    logic [CNT_WIDTH-1:0] neff;

    always_comb begin
        neff = i_debounce_cycles;
        if (i_debounce_cycles == '0) begin
            neff = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        gpio_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH),
            .RESET_BIT   (RESET_VALUE[g])
        ) u_bit (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_pin     (i_pins[g]),
            .i_neff    (neff),
            .i_bypass  (i_bypass[g]),
            .o_level   (o_pins[g]),
            .o_rise    (o_rise[g]),
            .o_fall    (o_fall[g])
        );
    end

    assign o_pin_change = o_rise | o_fall;

endmodule
